cva6_obi_mem_responder: RTL and testbench
=========================================

# cva6_obi_mem_responder

OBI subordinate (responder) terminating one CVA6 OBI request channel (fetch, load, store or AMO) into a local word-addressed memory. It sits on the NoC side opposite the CVA6 OBI adapter. It grants requests, tracks up to MaxOutstanding in-flight transactions, and returns in-order responses with echoed IDs under rready back-pressure. It is the simulation and bring-up target for the core's OBI ports.

## Interface
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration.
- obi_req_t, logic: OBI request struct. Fields used: req, reqpar, a.addr, a.we, a.be, a.wdata, a.aid, a.a_optional.atop, rready, rreadypar.
- obi_rsp_t, logic: OBI response struct. Fields driven: gnt, gntpar, rvalid, rvalidpar, r.rdata, r.rid, r.err.
- DataWidth, 64: width of wdata and rdata; byte enables are DataWidth/8.
- NumWords, 1024: memory depth in DataWidth words. Power of two.
- BaseAddr, 64'h8000_0000: byte address of word 0. Aligned to the memory size.
- MaxOutstanding, 4: response FIFO depth. Power of two, at least 1.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- obi_req_i  input  obi_req_t  request from the initiator.
- obi_rsp_o  output  obi_rsp_t  response to the initiator.
- parity_err_o  output  1  sticky flag: handshake parity mismatch detected.

## Operation
- Credit: count = entries in the response FIFO (0..MaxOutstanding).
- gnt = req AND (count < MaxOutstanding). gnt is combinational.
- Accept = req AND gnt.
- On accept, word index = (addr − BaseAddr) >> log2(DataWidth/8). The low address bits are ignored.
- Classification on accept, in priority order:
  - Address out of range: [BaseAddr, BaseAddr + NumWords·DataWidth/8) is in range. Out of range gives err=1, rdata=0, no memory access.
  - atop ≠ 0: err=1, rdata=0, no write. Atomics are not supported.
  - we=1: write the bytes where be[i]=1. Response has rdata=0, err=0.
  - we=0: rdata = current word (pre-write value). be is ignored. err=0.
- Every accepted request pushes exactly one entry {rdata, rid=aid, err} into the FIFO. Responses return in acceptance order.
- Response channel: rvalid = FIFO not empty, and r = FIFO head. Pop when rvalid AND rready.
- While rvalid=1 and rready=0, r stays stable.
- Accept and pop in the same cycle leave count unchanged. When full, a same-cycle pop does not raise gnt; gnt depends on the registered count only.
- Memory contents are not reset. Reading a word before it has been written returns X, which is legal.

## Timing
- Minimum latency: request accepted in cycle N gives rvalid=1 in cycle N+1.
- A read in cycle N+1 observes a write accepted in cycle N.
- Throughput is one accept per cycle while count < MaxOutstanding and rready is held high.
- Reset values: gnt=0, rvalid=0, rdata=0, rid=0, err=0, count=0, parity_err_o=0. FIFO pointers are 0.
- The request-side parity outputs reset to the inactive encoding; see Configuration.
- Reset asserted mid-operation discards all in-flight responses immediately (asynchronous). Memory contents are retained.

## Configuration
- Macro: CVA6_OBI_RSP_PARITY_EN.
- Defined:
  - gntpar = !gnt and rvalidpar = !rvalid; at reset both are 1.
  - reqpar == req: the request is treated as req=0 (no accept) and parity_err_o is set.
  - rreadypar == rready while rvalid=1: no pop occurs and parity_err_o is set.
  - parity_err_o clears only on reset.
- Undefined: gntpar=0 and rvalidpar=0 constantly. No checks are performed and parity_err_o=0.

## Test plan
- Write then read: write addr 0x8000_0008, wdata 0x1122334455667788, be=0xFF, aid=3; then read the same address with aid=5. Expect responses in order: {err=0, rid=3}, then {rdata=0x1122334455667788, rid=5}. The read's rvalid is one cycle after its accept.
- Partial write: write be=0x0F, wdata=0xAAAAAAAA_BBBBBBBB over the previous word, then read. Expect 0x11223344_BBBBBBBB.
- Back-pressure and full: rready=0, issue 5 reads on consecutive cycles.
  - gnt is high for 4 accepts and low on the 5th; rvalid holds head rid stable.
  - Raise rready: 4 in-order pops occur, and the 5th request is granted the cycle after the first pop.
- Errors: read at 0x7FFF_FFF8 gives err=1, rdata=0. Write with atop=0x2F gives err=1 and the memory is unchanged on readback.
- Reset mid-flight: with 3 responses pending, pulse rst_ni low asynchronously. rvalid=0 immediately; after release, gnt=req, and the next read returns the previously written data.
- Parity (macro defined): drive req=1, reqpar=1. Expect no gnt and parity_err_o=1, which stays 1 until reset.

Source files
------------

// File: rtl/cva6_obi_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cva6_obi_mem_responder: OBI subordinate backing one CVA6 request channel
// with a local word memory and an in-order response FIFO.
// Optional handshake parity: define CVA6_OBI_RSP_PARITY_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------

package cva6_obi_mem_responder_pkg;
    typedef struct packed {
        logic [5:0] atop;
    } default_obi_a_optional_t;

    typedef struct packed {
        logic [63:0]             addr;
        logic                    we;
        logic [7:0]              be;
        logic [63:0]             wdata;
        logic [3:0]              aid;
        default_obi_a_optional_t a_optional;
    } default_obi_a_chan_t;

    typedef struct packed {
        logic                req;
        logic                reqpar;
        default_obi_a_chan_t a;
        logic                rready;
        logic                rreadypar;
    } default_obi_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } default_obi_r_chan_t;

    typedef struct packed {
        logic                gnt;
        logic                gntpar;
        logic                rvalid;
        logic                rvalidpar;
        default_obi_r_chan_t r;
    } default_obi_rsp_t;
endpackage

module cva6_obi_mem_responder #(
    parameter int          CVA6Cfg        = 0,
    parameter type         obi_req_t      = cva6_obi_mem_responder_pkg::default_obi_req_t,
    parameter type         obi_rsp_t      = cva6_obi_mem_responder_pkg::default_obi_rsp_t,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned NumWords       = 1024,
    parameter logic [63:0] BaseAddr       = 64'h8000_0000,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     parity_err_o
);

    localparam int unsigned BYTES     = DataWidth / 8;
    localparam int unsigned OFF_W     = $clog2(BYTES);
    localparam int unsigned IDX_W     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned PTR_W     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CNT_W     = $clog2(MaxOutstanding + 1);
    localparam int unsigned ID_W      = $bits(obi_rsp_o.r.rid);
    localparam logic [63:0] MEM_BYTES = 64'(NumWords) * 64'(BYTES);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MaxOutstanding);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MaxOutstanding - 1);

    logic                 req_ok;
    logic                 rready_ok;
    logic                 gnt;
    logic                 accept;
    logic                 rvalid;
    logic                 pop;
    logic [63:0]          offset;
    logic                 in_range;
    logic                 is_atomic;
    logic [IDX_W-1:0]     idx;
    logic [DataWidth-1:0] push_rdata;
    logic                 push_err;

    logic [DataWidth-1:0]      mem        [NumWords];
    logic [DataWidth-1:0]      fifo_rdata [MaxOutstanding];
    logic [ID_W-1:0]           fifo_rid   [MaxOutstanding];
    logic [MaxOutstanding-1:0] fifo_err;
    logic [PTR_W-1:0]          wptr;
    logic [PTR_W-1:0]          rptr;
    logic [CNT_W-1:0]          count;

`ifdef CVA6_OBI_RSP_PARITY_EN
    // A parity bit equal to its signal marks the strobe as corrupt; ignore it.
    assign req_ok    = obi_req_i.req & (obi_req_i.reqpar != obi_req_i.req);
    assign rready_ok = obi_req_i.rready & (obi_req_i.rreadypar != obi_req_i.rready);
`else
    logic unused_parity;
    assign req_ok        = obi_req_i.req;
    assign rready_ok     = obi_req_i.rready;
    assign unused_parity = obi_req_i.reqpar ^ obi_req_i.rreadypar;
`endif

    // Grant is held low while reset is asserted so its reset value is 0.
    assign gnt    = rst_ni & req_ok & (count < MAX_CNT);
    assign accept = gnt;
    assign rvalid = (count != '0);
    assign pop    = rvalid & rready_ok;

    // Unsigned wrap makes addresses below BaseAddr land out of range as well.
    assign offset    = 64'(obi_req_i.a.addr) - BaseAddr;
    assign in_range  = (offset < MEM_BYTES);
    assign is_atomic = (obi_req_i.a.a_optional.atop != '0);
    assign idx       = offset[OFF_W +: IDX_W];

    always_comb begin
        push_rdata = '0;
        push_err   = 1'b0;
        if (!in_range || is_atomic) begin
            push_err = 1'b1;
        end else if (!obi_req_i.a.we) begin
            push_rdata = mem[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && in_range && !is_atomic && obi_req_i.a.we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (obi_req_i.a.be[i]) begin
                    mem[idx][8*i +: 8] <= obi_req_i.a.wdata[8*i +: 8];
                end
            end
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            fifo_err <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_rdata[i] <= '0;
                fifo_rid[i]   <= '0;
            end
        end else begin
            if (accept) begin
                fifo_rdata[wptr] <= push_rdata;
                fifo_rid[wptr]   <= obi_req_i.a.aid;
                fifo_err[wptr]   <= push_err;
                wptr             <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef CVA6_OBI_RSP_PARITY_EN
    logic parity_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_err <= 1'b0;
        end else if ((obi_req_i.reqpar == obi_req_i.req) ||
                     (rvalid && (obi_req_i.rreadypar == obi_req_i.rready))) begin
            parity_err <= 1'b1;
        end
    end

    assign parity_err_o = parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = gnt;
        obi_rsp_o.rvalid  = rvalid;
        obi_rsp_o.r.rdata = fifo_rdata[rptr];
        obi_rsp_o.r.rid   = fifo_rid[rptr];
        obi_rsp_o.r.err   = fifo_err[rptr];
`ifdef CVA6_OBI_RSP_PARITY_EN
        obi_rsp_o.gntpar    = ~gnt;
        obi_rsp_o.rvalidpar = ~rvalid;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_cva6_obi_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cva6_obi_mem_responder: directed stimulus against a queue/array model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cva6_obi_mem_responder;

    typedef cva6_obi_mem_responder_pkg::default_obi_req_t req_t;
    typedef cva6_obi_mem_responder_pkg::default_obi_rsp_t rsp_t;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SIZE = 64'd8192;
    localparam int          MAXO = 4;

    typedef struct {
        logic [63:0] rdata;
        logic [3:0]  rid;
        logic        err;
        bit          known;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    req_t obi_req;
    rsp_t obi_rsp;
    logic parity_err;

    logic        req_v = 1'b0;
    logic        par_inj = 1'b0;
    logic        rready_v = 1'b1;
    logic [63:0] a_addr = '0;
    logic        a_we = 1'b0;
    logic [7:0]  a_be = '0;
    logic [63:0] a_wdata = '0;
    logic [3:0]  a_aid = '0;
    logic [5:0]  a_atop = '0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    exp_t        exp_q[$];
    exp_t        got_q[$];
    logic [63:0] model_mem[longint];
    bit          par_flag = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        obi_req                   = '0;
        obi_req.req               = req_v;
        obi_req.reqpar            = par_inj ? req_v : ~req_v;
        obi_req.a.addr            = a_addr;
        obi_req.a.we              = a_we;
        obi_req.a.be              = a_be;
        obi_req.a.wdata           = a_wdata;
        obi_req.a.aid             = a_aid;
        obi_req.a.a_optional.atop = a_atop;
        obi_req.rready            = rready_v;
        obi_req.rreadypar         = ~rready_v;
    end

    cva6_obi_mem_responder #(
        .obi_req_t(req_t),
        .obi_rsp_t(rsp_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .obi_req_i   (obi_req),
        .obi_rsp_o   (obi_rsp),
        .parity_err_o(parity_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: predicts outputs from the handshake rules, then steps across the next edge.
    always @(negedge clk) begin
        logic req_eff, ready_eff, exp_gnt, exp_rv;
        exp_t e;
        logic [63:0] w;
        if (!rst_n) begin
            exp_q.delete();
            par_flag = 0;
        end else begin
            req_eff   = obi_req.req;
            ready_eff = obi_req.rready;
`ifdef CVA6_OBI_RSP_PARITY_EN
            if (obi_req.reqpar == obi_req.req) req_eff = 1'b0;
            if (obi_req.rreadypar == obi_req.rready) ready_eff = 1'b0;
`endif
            exp_gnt = req_eff && (exp_q.size() < MAXO);
            exp_rv  = (exp_q.size() != 0);
            check("gnt", 64'(obi_rsp.gnt), 64'(exp_gnt));
            check("rvalid", 64'(obi_rsp.rvalid), 64'(exp_rv));
            if (exp_rv) begin
                check("rid", 64'(obi_rsp.r.rid), 64'(exp_q[0].rid));
                check("err", 64'(obi_rsp.r.err), 64'(exp_q[0].err));
                if (exp_q[0].known) check("rdata", obi_rsp.r.rdata, exp_q[0].rdata);
            end
`ifdef CVA6_OBI_RSP_PARITY_EN
            check("gntpar", 64'(obi_rsp.gntpar), 64'(!exp_gnt));
            check("rvalidpar", 64'(obi_rsp.rvalidpar), 64'(!exp_rv));
            check("parity_err", 64'(parity_err), 64'(par_flag));
            if ((obi_req.reqpar == obi_req.req) || (exp_rv && obi_req.rreadypar == obi_req.rready))
                par_flag = 1;
`else
            check("gntpar", 64'(obi_rsp.gntpar), 64'd0);
            check("rvalidpar", 64'(obi_rsp.rvalidpar), 64'd0);
            check("parity_err", 64'(parity_err), 64'd0);
`endif
            if (exp_rv && ready_eff) begin
                got_q.push_back('{obi_rsp.r.rdata, obi_rsp.r.rid, obi_rsp.r.err, 1'b1});
                void'(exp_q.pop_front());
            end
            if (exp_gnt) begin
                e = '{64'd0, obi_req.a.aid, 1'b0, 1'b1};
                if (obi_req.a.addr < BASE || obi_req.a.addr >= BASE + SIZE) begin
                    e.err = 1'b1;
                end else if (obi_req.a.a_optional.atop != 0) begin
                    e.err = 1'b1;
                end else begin
                    w = (obi_req.a.addr - BASE) / 8;
                    if (obi_req.a.we) begin
                        if (model_mem.exists(longint'(w)) || obi_req.a.be == 8'hFF) begin
                            logic [63:0] v;
                            v = model_mem.exists(longint'(w)) ? model_mem[longint'(w)] : 64'd0;
                            for (int b = 0; b < 8; b++)
                                if (obi_req.a.be[b]) v[8*b +: 8] = obi_req.a.wdata[8*b +: 8];
                            model_mem[longint'(w)] = v;
                        end
                    end else if (model_mem.exists(longint'(w))) begin
                        e.rdata = model_mem[longint'(w)];
                    end else begin
                        e.known = 1'b0;
                    end
                end
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [63:0] addr, input logic we, input logic [7:0] be,
                        input logic [63:0] wd, input logic [3:0] id, input logic [5:0] atop,
                        output int acc_cyc);
        int waited = 0;
        req_v = 1'b1; a_addr = addr; a_we = we; a_be = be; a_wdata = wd; a_aid = id; a_atop = atop;
        @(negedge clk);
        while (!obi_rsp.gnt && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!obi_rsp.gnt) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got gnt=0 expected gnt=1 for aid %0d", id);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_v = 1'b0; a_atop = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc5, raise;
        repeat (2) @(posedge clk);
        #1;
        req_v = 1'b1;
        #1;
        check("reset_gnt", 64'(obi_rsp.gnt), 64'd0);
        check("reset_rvalid", 64'(obi_rsp.rvalid), 64'd0);
        check("reset_rdata", obi_rsp.r.rdata, 64'd0);
        check("reset_rid", 64'(obi_rsp.r.rid), 64'd0);
        check("reset_err", 64'(obi_rsp.r.err), 64'd0);
        check("reset_parity_err", 64'(parity_err), 64'd0);
        req_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back.
        got_q.delete();
        send(64'h8000_0008, 1, 8'hFF, 64'h1122334455667788, 4'd3, 0, acc);
        send(64'h8000_0008, 0, 8'h00, 64'd0, 4'd5, 0, acc);
        check("rd_latency_rvalid", 64'(obi_rsp.rvalid), 64'd1);
        drain();
        check("wr_rsp_rid", 64'(got_q[0].rid), 64'd3);
        check("wr_rsp_err", 64'(got_q[0].err), 64'd0);
        check("rd_rsp_rid", 64'(got_q[1].rid), 64'd5);
        check("rd_rsp_data", got_q[1].rdata, 64'h1122334455667788);

        // Partial write.
        got_q.delete();
        send(64'h8000_0008, 1, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 4'd1, 0, acc);
        send(64'h8000_000C, 0, 8'h00, 64'd0, 4'd2, 0, acc);
        drain();
        check("partial_data", got_q[1].rdata, 64'h11223344_BBBBBBBB);

        // Back-pressure until full, then release.
        got_q.delete();
        rready_v = 1'b0;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send(64'h8000_0008, 0, 8'h00, 64'd0, 4'(k), 0, acc5);
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                check("full_gnt_low", 64'(obi_rsp.gnt), 64'd0);
                check("full_rvalid", 64'(obi_rsp.rvalid), 64'd1);
                check("full_head_rid", 64'(obi_rsp.r.rid), 64'd1);
                @(posedge clk);
                #1;
                check("stable_head_rid", 64'(obi_rsp.r.rid), 64'd1);
                raise = cyc;
                rready_v = 1'b1;
            end
        join
        drain();
        check("fifth_grant_cycle", 64'(acc5), 64'(raise + 2));
        check("pop_count", 64'(got_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) check("pop_order_rid", 64'(got_q[k].rid), 64'(k + 1));

        // Error responses and range boundaries.
        got_q.delete();
        send(64'h7FFF_FFF8, 0, 8'h00, 64'd0, 4'd6, 0, acc);
        send(64'h8000_0008, 1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 6'h2F, acc);
        send(64'h8000_0008, 0, 8'h00, 64'd0, 4'd8, 0, acc);
        send(64'h8000_1FF8, 1, 8'hFF, 64'hDEAD_BEEF_0123_4567, 4'd10, 0, acc);
        send(64'h8000_1FF8, 0, 8'h00, 64'd0, 4'd11, 0, acc);
        send(64'h8000_2000, 0, 8'h00, 64'd0, 4'd12, 0, acc);
        drain();
        check("oor_err", 64'(got_q[0].err), 64'd1);
        check("oor_rdata", got_q[0].rdata, 64'd0);
        check("atop_err", 64'(got_q[1].err), 64'd1);
        check("atop_unchanged", got_q[2].rdata, 64'h11223344_BBBBBBBB);
        check("last_word", got_q[4].rdata, 64'hDEAD_BEEF_0123_4567);
        check("past_end_err", 64'(got_q[5].err), 64'd1);

        // Asynchronous reset with responses in flight.
        got_q.delete();
        rready_v = 1'b0;
        for (int k = 1; k <= 3; k++) send(64'h8000_0008, 0, 8'h00, 64'd0, 4'(k), 0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rvalid", 64'(obi_rsp.rvalid), 64'd0);
        check("async_rst_rid", 64'(obi_rsp.r.rid), 64'd0);
        req_v = 1'b1; a_addr = 64'h8000_0008; a_we = 1'b0; a_aid = 4'd9;
        #1;
        check("in_rst_gnt", 64'(obi_rsp.gnt), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        rready_v = 1'b1;
        #1;
        check("post_rst_gnt", 64'(obi_rsp.gnt), 64'd1);
        send(64'h8000_0008, 0, 8'h00, 64'd0, 4'd9, 0, acc);
        drain();
        check("post_rst_count", 64'(got_q.size()), 64'd1);
        check("post_rst_data", got_q[0].rdata, 64'h11223344_BBBBBBBB);

`ifdef CVA6_OBI_RSP_PARITY_EN
        par_inj = 1'b1;
        req_v = 1'b1; a_addr = 64'h8000_0008; a_we = 1'b0;
        #1;
        check("par_no_gnt", 64'(obi_rsp.gnt), 64'd0);
        @(posedge clk);
        #1;
        check("par_err_set", 64'(parity_err), 64'd1);
        par_inj = 1'b0;
        req_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("par_err_sticky", 64'(parity_err), 64'd1);
        rst_n = 1'b0;
        #1;
        check("par_err_cleared", 64'(parity_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
